// File: rtl/spi_bram_pkg.sv
// Shared constants and FSM encoding for the SPI-to-BRAM bridge.
// Command bytes and synchroniser depth live here.
package spi_bram_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WR_DATA,
      RD_DATA,
      DISCARD
   } state_t;

endpackage

// File: rtl/spi_bram_bridge_if.sv
// ap_memory-style BRAM port driven by the SPI bridge.
// The bridge takes the master side; the RAM takes the slave side.
interface spi_bram_bridge_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    bram_addr;
   logic             bram_ce;
   logic             bram_we;
   logic [WIDTH-1:0] bram_d;
   logic [WIDTH-1:0] bram_q;

   modport master (
      output bram_addr,
      output bram_ce,
      output bram_we,
      output bram_d,
      input  bram_q
   );

   modport slave (
      input  bram_addr,
      input  bram_ce,
      input  bram_we,
      input  bram_d,
      output bram_q
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin.
// Gives the synced level plus one-cycle rise/fall pulses.
module spi_sync_edge
   import spi_bram_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_bram_bridge.sv
// SPI mode-0 slave that reads/writes words in one BRAM port.
// Frame: CMD byte, ADDR byte, then WIDTH-bit words, MSB first.
module spi_bram_bridge
   import spi_bram_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   spi_bram_bridge_if.master bram,
   output logic              busy,
   output logic              frame_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);

   function automatic logic [AW-1:0] next_addr(
      input logic [AW-1:0] a
   );
      return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync_edge u_sclk (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi_sclk),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge u_cs (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi_cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync_edge u_mosi (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi_mosi),
      .level (mosi_lvl),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   state_t           state;
   logic             armed;
   logic [CW-1:0]    cnt;
   logic [7:0]       cmd_byte;
   logic [WIDTH-1:0] rx_shift;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rd_buf;
   logic [AW-1:0]    cur;
   logic [1:0]       rd_pipe;
   logic             load_next;

   logic [WIDTH-1:0] rx_next;
   logic             last_byte;
   logic             last_word;
   logic             unused_ok;

   assign rx_next   = {rx_shift[WIDTH-2:0], mosi_lvl};
   assign last_byte = (cnt == CW'(7));
   assign last_word = (cnt == CW'(WIDTH - 1));

   assign unused_ok = &{1'b0, sclk_lvl, cs_rise, cs_fall,
                        mosi_rise, mosi_fall,
                        rx_shift[WIDTH-1], tx_shift[WIDTH-1]};

   // armed stays low after reset until CS is seen high, so a frame
   // already in progress at reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         armed          <= 1'b0;
         cnt            <= '0;
         cmd_byte       <= '0;
         rx_shift       <= '0;
         tx_shift       <= '0;
         rd_buf         <= '0;
         cur            <= '0;
         rd_pipe        <= '0;
         load_next      <= 1'b0;
         spi_miso       <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         bram.bram_addr <= '0;
         bram.bram_ce   <= 1'b0;
         bram.bram_we   <= 1'b0;
         bram.bram_d    <= '0;
      end else begin
         bram.bram_ce <= 1'b0;
         bram.bram_we <= 1'b0;
         frame_done   <= 1'b0;
         rd_pipe      <= {rd_pipe[0], 1'b0};
         if (cs_lvl) begin
            armed <= 1'b1;
         end
         // q is valid the cycle after the ce cycle
         if (rd_pipe[1]) begin
            rd_buf <= bram.bram_q;
            cur    <= next_addr(cur);
         end
         if (cs_lvl) begin
            frame_done <= (state != IDLE);
            state      <= IDLE;
            busy       <= 1'b0;
            spi_miso   <= 1'b0;
            cnt        <= '0;
            load_next  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (armed) begin
                     state <= CMD;
                     busy  <= 1'b1;
                     cnt   <= '0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     cnt      <= cnt + 1'b1;
                     if (last_byte) begin
                        cmd_byte <= rx_next[7:0];
                        cnt      <= '0;
                        state    <= ADDR;
                     end
                  end
               end
               ADDR: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     cnt      <= cnt + 1'b1;
                     if (last_byte) begin
                        cnt <= '0;
                        cur <= rx_next[AW-1:0];
                        unique case (1'b1)
                           (cmd_byte == CMD_WRITE): begin
                              state <= WR_DATA;
                           end
                           (cmd_byte == CMD_READ): begin
                              state          <= RD_DATA;
                              bram.bram_addr <= rx_next[AW-1:0];
                              bram.bram_ce   <= 1'b1;
                              rd_pipe        <= 2'b01;
                              load_next      <= 1'b1;
                           end
                           default: begin
                              state <= DISCARD;
                           end
                        endcase
                     end
                  end
               end
               WR_DATA: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_next;
                     cnt      <= cnt + 1'b1;
                     if (last_word) begin
                        cnt            <= '0;
                        bram.bram_addr <= cur;
                        bram.bram_d    <= rx_next;
                        bram.bram_ce   <= 1'b1;
                        bram.bram_we   <= 1'b1;
                        cur            <= next_addr(cur);
                     end
                  end
               end
               RD_DATA: begin
                  if (sclk_rise) begin
                     cnt <= cnt + 1'b1;
                     if (last_word) begin
                        cnt            <= '0;
                        bram.bram_addr <= cur;
                        bram.bram_ce   <= 1'b1;
                        rd_pipe        <= 2'b01;
                        load_next      <= 1'b1;
                     end
                  end
                  if (sclk_fall) begin
                     if (load_next) begin
                        tx_shift  <= rd_buf;
                        spi_miso  <= rd_buf[WIDTH-1];
                        load_next <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        spi_miso <= tx_shift[WIDTH-2];
                     end
                  end
               end
               DISCARD: begin
                  spi_miso <= 1'b0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_bram_bridge.sv
// Directed bench for spi_bram_bridge: SPI host, BRAM model,
// access monitor and immediate-assertion checks.
module tb_spi_bram_bridge;
   import spi_bram_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic spi_sclk = 1'b0;
   logic spi_cs_n = 1'b1;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   logic busy;
   logic frame_done;

   spi_bram_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

   spi_bram_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .bram       (bif),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [DEPTH];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   int checks = 0;
   int errors = 0;
   int ce_n = 0, wr_n = 0, rd_n = 0;
   int b2b = 0, fd_n = 0, miso_hi = 0;
   logic        ce_prev = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   int          rd_log [64];

   // RAM model with registered read, plus access monitor
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (bif.bram_ce) begin
         ce_n++;
         if (ce_prev) b2b++;
         if (bif.bram_we) begin
            mem[bif.bram_addr] <= bif.bram_d;
            wr_n++;
            wr_addr = bif.bram_addr;
            wr_data = bif.bram_d;
         end else begin
            bif.bram_q <= mem[bif.bram_addr];
            if (rd_n < 64) rd_log[rd_n] = int'(bif.bram_addr);
            rd_n++;
         end
      end
      ce_prev = bif.bram_ce;
      if (frame_done) fd_n++;
      if (spi_miso) miso_hi++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      pre_addr = a[3:0];
      pre_data = d;
      pre_en   = 1'b1;
      #10;
      pre_en   = 1'b0;
   endtask

   task automatic bit_x(input logic b, output logic r);
      spi_mosi = b;
      #40;
      r        = spi_miso;
      spi_sclk = 1'b1;
      #40;
      spi_sclk = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] w, input int n,
                       output logic [31:0] r);
      logic rb;
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bit_x(w[i], rb);
         r = {r[30:0], rb};
      end
   endtask

   task automatic cs_on();
      spi_cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_off();
      #40;
      spi_cs_n = 1'b1;
      #200;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [31:0] exp_w [4];
      int c0, w0, f0, r0, m0;

      exp_w[0] = 32'h8000_0001;
      exp_w[1] = 32'h7FFF_FFFE;
      exp_w[2] = 32'hA5A5_5A5A;
      exp_w[3] = 32'h0F0F_F0F0;

      #2;
      #100;
      rst = 1'b0;
      #100;
      chk("rst_miso", spi_miso, 0);
      chk("rst_ce", bif.bram_ce, 0);
      chk("rst_we", bif.bram_we, 0);
      chk("rst_addr", bif.bram_addr, 0);
      chk("rst_d", bif.bram_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fd", frame_done, 0);

      // single write
      w0 = wr_n; f0 = fd_n; c0 = ce_n;
      cs_on();
      chk("busy_on", busy, 1);
      xfer(32'h57, 8, r);
      xfer(32'h03, 8, r);
      xfer(32'hDEADBEEF, 32, r);
      chk("wr_count", wr_n - w0, 1);
      chk("wr_addr", wr_addr, 3);
      chk("wr_data", wr_data, 32'hDEADBEEF);
      cs_off();
      chk("wr_fd", fd_n - f0, 1);
      chk("wr_busy_off", busy, 0);
      chk("wr_mem3", mem[3], 32'hDEADBEEF);
      chk("wr_ce_total", ce_n - c0, 1);

      // burst read wrapping 15 -> 0
      preload(15, 32'h1111_1111);
      preload(0, 32'h2222_2222);
      r0 = rd_n;
      cs_on();
      xfer(32'h52, 8, r);
      xfer(32'h0F, 8, r);
      xfer(32'h0, 32, r);
      chk("rd_word0", r, 32'h1111_1111);
      xfer(32'h0, 32, r);
      chk("rd_word1", r, 32'h2222_2222);
      cs_off();
      chk("rd_addr0", rd_log[r0], 15);
      chk("rd_addr1", rd_log[r0 + 1], 0);

      // partial word is dropped
      preload(5, 32'h55AA_55AA);
      w0 = wr_n; f0 = fd_n;
      cs_on();
      xfer(32'h57, 8, r);
      xfer(32'h05, 8, r);
      xfer(32'hABCDE, 20, r);
      cs_off();
      chk("part_no_wr", wr_n - w0, 0);
      chk("part_mem5", mem[5], 32'h55AA_55AA);
      chk("part_idle", dut.state, IDLE);
      chk("part_fd", fd_n - f0, 1);

      // invalid command
      c0 = ce_n; m0 = miso_hi; f0 = fd_n;
      cs_on();
      xfer(32'hA5, 8, r);
      xfer(32'h01, 8, r);
      xfer(32'hFFFF_FFFF, 32, r);
      chk("inv_miso_data", r, 0);
      cs_off();
      chk("inv_no_ce", ce_n - c0, 0);
      chk("inv_miso_low", miso_hi - m0, 0);
      chk("inv_fd", fd_n - f0, 1);

      // reset after 12 bits of a write frame
      c0 = ce_n;
      cs_on();
      xfer(32'h57, 8, r);
      xfer(32'h0, 4, r);
      rst = 1'b1;
      #20;
      chk("mrst_miso", spi_miso, 0);
      chk("mrst_ce", bif.bram_ce, 0);
      chk("mrst_we", bif.bram_we, 0);
      chk("mrst_addr", bif.bram_addr, 0);
      chk("mrst_d", bif.bram_d, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_fd", frame_done, 0);
      chk("mrst_idle", dut.state, IDLE);
      rst = 1'b0;
      f0 = fd_n;
      xfer(32'h2, 4, r);
      xfer(32'h57, 8, r);
      xfer(32'h02, 8, r);
      xfer(32'h1234_5678, 32, r);
      cs_off();
      chk("mrst_ignored_ce", ce_n - c0, 0);
      chk("mrst_ignored_fd", fd_n - f0, 0);
      cs_on();
      xfer(32'h57, 8, r);
      xfer(32'h02, 8, r);
      xfer(32'h0000_CAFE, 32, r);
      cs_off();
      chk("mrst_mem2", mem[2], 32'h0000_CAFE);
      chk("mrst_wr_addr", wr_addr, 2);
      chk("mrst_ce_one", ce_n - c0, 1);

      // 4-word read burst at f_clk = 8 * f_sclk
      for (int i = 0; i < 4; i++) preload(i, exp_w[i]);
      r0 = rd_n;
      cs_on();
      xfer(32'h52, 8, r);
      xfer(32'h00, 8, r);
      for (int i = 0; i < 4; i++) begin
         xfer(32'h0, 32, r);
         chk($sformatf("burst_w%0d", i), r, exp_w[i]);
      end
      cs_off();
      chk("burst_reads", rd_n - r0, 5);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst_a%0d", i), rd_log[r0 + i], i);
      end
      chk("ce_never_b2b", b2b, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
